// File: rtl/bt656_video_decoder.sv
// BT.656 byte-stream decoder: locks to EAV/SAV timing codes and emits active-video
// pixel pairs {Cb,Y0,Cr,Y1} with pair/line/field position and a framing error count.
module bt656_video_decoder #(
    parameter int PAIRS_PER_LINE = 360,
    parameter int LINE_W         = 10,
    parameter int ERR_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        td_data,
    input  logic              enable,
    output logic              pair_valid,
    output logic [31:0]       pair_data,
    output logic [8:0]        pair_x,
    output logic [LINE_W-1:0] line_y,
    output logic              field,
    output logic              field_start,
    output logic              line_start,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [8:0] PPL = 9'(PAIRS_PER_LINE);

    typedef enum logic [2:0] {SEARCH, PRE1, PRE2, XY, ACTIVE, BLANK} state_t;

    state_t      state, state_nxt;
    logic [7:0]  td_q;
    logic [1:0]  phase;
    logic [7:0]  cb_q, y0_q, cr_q;
    logic [8:0]  pair_cnt;
    logic        overlong_seen;
    logic        v_prev;

    logic        code_f, code_v, code_h, code_ok;
    logic        td_ff, td_00;
    logic        sav_active, code_bad, group_done, trunc_err, overflow_err, emit, err_inc;

    assign td_ff  = (td_q == 8'hFF);
    assign td_00  = (td_q == 8'h00);
    assign code_f = td_q[6];
    assign code_v = td_q[5];
    assign code_h = td_q[4];
    assign code_ok = td_q[7] &&
                     (td_q[3:0] == {code_v ^ code_h, code_f ^ code_h,
                                    code_f ^ code_v, code_f ^ code_v ^ code_h});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
            td_q  <= 8'h00;
        end else begin
            state <= state_nxt;
            td_q  <= td_data;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SEARCH, BLANK: if (td_ff) state_nxt = PRE1;
            PRE1:   state_nxt = td_00 ? PRE2 : (td_ff ? PRE1 : SEARCH);
            PRE2:   state_nxt = td_00 ? XY   : (td_ff ? PRE1 : SEARCH);
            XY: begin
                if (!code_ok)
                    state_nxt = SEARCH;
                else if (!code_h && !code_v)
                    state_nxt = ACTIVE;
                else
                    state_nxt = BLANK;
            end
            ACTIVE: if (td_ff) state_nxt = PRE1;
            default: state_nxt = SEARCH;
        endcase
    end

    // Event decode; several error sources in one cycle collapse into a single increment.
    always_comb begin
        sav_active   = (state == XY) && code_ok && !code_h && !code_v;
        code_bad     = (state == XY) && !code_ok;
        group_done   = (state == ACTIVE) && !td_ff && (phase == 2'd3);
        trunc_err    = (state == ACTIVE) && td_ff && (phase != 2'd0);
        overflow_err = group_done && (pair_cnt == PPL) && !overlong_seen;
        emit         = group_done && enable && (pair_cnt < PPL);
        err_inc      = code_bad || trunc_err || overflow_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_valid    <= 1'b0;
            field_start   <= 1'b0;
            line_start    <= 1'b0;
            locked        <= 1'b0;
            field         <= 1'b0;
            v_prev        <= 1'b1;
            line_y        <= '0;
            err_count     <= '0;
        end else begin
            pair_valid  <= emit;
            line_start  <= sav_active;
            field_start <= sav_active && v_prev;
            if (err_inc && (err_count != '1))
                err_count <= err_count + 1'b1;
            if (state == XY) begin
                locked <= code_ok;
                if (code_ok) begin
                    field  <= code_f;
                    v_prev <= code_v;
                end
            end
            if (sav_active)
                line_y <= v_prev ? '0 : line_y + 1'b1;
        end
    end

    // Pair assembly; pair_x only moves on an emitted pair so it holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase         <= 2'd0;
            cb_q          <= 8'h00;
            y0_q          <= 8'h00;
            cr_q          <= 8'h00;
            pair_cnt      <= 9'd0;
            overlong_seen <= 1'b0;
            pair_x        <= 9'd0;
            pair_data     <= 32'h0;
        end else if (sav_active) begin
            phase         <= 2'd0;
            pair_cnt      <= 9'd0;
            overlong_seen <= 1'b0;
            pair_x        <= 9'd0;
        end else if ((state == ACTIVE) && !td_ff) begin
            phase <= phase + 2'd1;
            unique case (phase)
                2'd0: cb_q <= td_q;
                2'd1: y0_q <= td_q;
                2'd2: cr_q <= td_q;
                2'd3: begin
                    if (pair_cnt != PPL)
                        pair_cnt <= pair_cnt + 9'd1;
                    if (overflow_err)
                        overlong_seen <= 1'b1;
                    if (emit) begin
                        pair_data <= {cb_q, y0_q, cr_q, td_q};
                        pair_x    <= pair_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
